// File: rtl/wb_port_arbiter_if.sv
// Register-file write port bundle: writeback request, MDU result handshake, RF write and pending-write status.
// The master modport is the environment side; the slave modport is the arbiter.
interface wb_port_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  wb_we_i;
   logic [ADDR_WIDTH-1:0] wb_rd_i;
   logic [DATA_WIDTH-1:0] wb_data_i;

   logic                  mdu_valid_i;
   logic                  mdu_ready_o;
   logic [ADDR_WIDTH-1:0] mdu_rd_i;
   logic [DATA_WIDTH-1:0] mdu_data_i;

   logic                  stall_w_o;
   logic                  rf_we_o;
   logic [ADDR_WIDTH-1:0] rf_waddr_o;
   logic [DATA_WIDTH-1:0] rf_wdata_o;
   logic                  pend_valid_o;
   logic [ADDR_WIDTH-1:0] pend_rd_o;

   modport master (
      output wb_we_i, wb_rd_i, wb_data_i,
      output mdu_valid_i, mdu_rd_i, mdu_data_i,
      input  mdu_ready_o, stall_w_o, rf_we_o, rf_waddr_o, rf_wdata_o,
      input  pend_valid_o, pend_rd_o
   );

   modport slave (
      input  wb_we_i, wb_rd_i, wb_data_i,
      input  mdu_valid_i, mdu_rd_i, mdu_data_i,
      output mdu_ready_o, stall_w_o, rf_we_o, rf_waddr_o, rf_wdata_o,
      output pend_valid_o, pend_rd_o
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the RF write port between writeback and a one-entry MDU result buffer; MDU writes >=1 cycle after accept.
// Writeback normally wins; a starved MDU result forces a write and stalls writeback; mdu_ready_o = buffer empty.
module wb_port_arbiter #(
   parameter int MAX_WAIT   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic              clk_i,
   input  logic              reset_i,
   wb_port_arbiter_if.slave  bus
);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic {IDLE = 1'b0, FORCE = 1'b1} state_t;

   state_t                state_q, state_d;
   logic                  buf_valid_q, buf_valid_d;
   logic [ADDR_WIDTH-1:0] buf_rd_q, buf_rd_d;
   logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
   logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;

   logic wb_use;
   logic grant_mdu;
   logic accept;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         buf_valid_q <= 1'b0;
         buf_rd_q    <= '0;
         buf_data_q  <= '0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         buf_valid_q <= buf_valid_d;
         buf_rd_q    <= buf_rd_d;
         buf_data_q  <= buf_data_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      buf_valid_d = buf_valid_q;
      buf_rd_d    = buf_rd_q;
      buf_data_d  = buf_data_q;
      wait_cnt_d  = wait_cnt_q;

      wb_use    = bus.wb_we_i && (bus.wb_rd_i != '0);
      grant_mdu = buf_valid_q && ((state_q == FORCE) || !wb_use);
      // Ready is purely the registered empty flag, so accept can never coincide with a grant.
      accept    = bus.mdu_valid_i && !buf_valid_q;

      if (grant_mdu) begin
         buf_valid_d = 1'b0;
      end else if (accept && (bus.mdu_rd_i != '0)) begin
         buf_valid_d = 1'b1;
         buf_rd_d    = bus.mdu_rd_i;
         buf_data_d  = bus.mdu_data_i;
      end

      case (state_q)
         IDLE: begin
            if (grant_mdu) begin
               wait_cnt_d = '0;
            end else if (buf_valid_q) begin
               if (wait_cnt_q != CNT_W'(MAX_WAIT)) begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
               if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                  state_d = FORCE;
               end
            end
         end
         FORCE: begin
            state_d    = IDLE;
            wait_cnt_d = '0;
         end
         default: begin
            state_d    = IDLE;
            wait_cnt_d = '0;
         end
      endcase

      bus.mdu_ready_o  = !buf_valid_q && !reset_i;
      bus.pend_valid_o = buf_valid_q && !reset_i;
      bus.pend_rd_o    = reset_i ? '0 : buf_rd_q;
      bus.stall_w_o    = (state_q == FORCE) && wb_use && !reset_i;
      bus.rf_we_o      = 1'b0;
      bus.rf_waddr_o   = '0;
      bus.rf_wdata_o   = '0;
      if (!reset_i) begin
         if (grant_mdu) begin
            bus.rf_we_o    = 1'b1;
            bus.rf_waddr_o = buf_rd_q;
            bus.rf_wdata_o = buf_data_q;
         end else begin
            bus.rf_we_o    = wb_use;
            bus.rf_waddr_o = bus.wb_rd_i;
            bus.rf_wdata_o = bus.wb_data_i;
         end
      end
   end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with MAX_WAIT=4, 32-bit data, 5-bit addresses.
module tb_wb_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   xfers    = 0;

   wb_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

   wb_port_arbiter #(.MAX_WAIT(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mdu_valid_i && bus.mdu_ready_o) xfers <= xfers + 1;
   end

   task automatic next_cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic we, input logic [4:0] rd, input logic [31:0] d,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
      bus.wb_we_i     = we;
      bus.wb_rd_i     = rd;
      bus.wb_data_i   = d;
      bus.mdu_valid_i = mv;
      bus.mdu_rd_i    = mrd;
      bus.mdu_data_i  = md;
   endtask

   task automatic do_reset;
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      rst = 1'b1;
      next_cyc();
      next_cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      set_in(1'b1, 5'd3, 32'h33, 1'b1, 5'd5, 32'h55);
      rst = 1'b1;
      next_cyc();
      #1;
      n_checks++;
      if ({bus.rf_we_o, bus.stall_w_o, bus.mdu_ready_o, bus.pend_valid_o} !== 4'b0000) begin
         $display("FAIL reset_ctrl got we/stall/rdy/pend=%b want 0000",
                  {bus.rf_we_o, bus.stall_w_o, bus.mdu_ready_o, bus.pend_valid_o});
         n_fail++;
      end
      n_checks++;
      if (bus.rf_waddr_o !== 5'd0 || bus.rf_wdata_o !== 32'd0 || bus.pend_rd_o !== 5'd0) begin
         $display("FAIL reset_data got addr=%0d data=%h pend_rd=%0d want 0/0/0",
                  bus.rf_waddr_o, bus.rf_wdata_o, bus.pend_rd_o);
         n_fail++;
      end
      bus.mdu_valid_i = 1'b0;
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.mdu_ready_o !== 1'b1 || bus.rf_we_o !== 1'b1 || bus.rf_waddr_o !== 5'd3) begin
         $display("FAIL reset_release got rdy=%b we=%b addr=%0d want 1/1/3",
                  bus.mdu_ready_o, bus.rf_we_o, bus.rf_waddr_o);
         n_fail++;
      end
   endtask

   task automatic test_idle_mdu;
      do_reset();
      set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
      #1;
      n_checks++;
      if (bus.mdu_ready_o !== 1'b1 || bus.rf_we_o !== 1'b0) begin
         $display("FAIL idle_cyc0 got rdy=%b we=%b want 1/0", bus.mdu_ready_o, bus.rf_we_o);
         n_fail++;
      end
      next_cyc();
      bus.mdu_valid_i = 1'b0;
      #1;
      n_checks++;
      if (bus.rf_we_o !== 1'b1 || bus.rf_waddr_o !== 5'd5 || bus.rf_wdata_o !== 32'hDEADBEEF ||
          bus.stall_w_o !== 1'b0 || bus.mdu_ready_o !== 1'b0) begin
         $display("FAIL idle_cyc1 got we=%b addr=%0d data=%h stall=%b rdy=%b want 1/5/deadbeef/0/0",
                  bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.stall_w_o, bus.mdu_ready_o);
         n_fail++;
      end
      next_cyc();
      #1;
      n_checks++;
      if (bus.mdu_ready_o !== 1'b1 || bus.rf_we_o !== 1'b0 || bus.pend_valid_o !== 1'b0) begin
         $display("FAIL idle_cyc2 got rdy=%b we=%b pend=%b want 1/0/0",
                  bus.mdu_ready_o, bus.rf_we_o, bus.pend_valid_o);
         n_fail++;
      end
   endtask

   task automatic test_force_starvation;
      do_reset();
      set_in(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
      #1;
      n_checks++;
      if (bus.rf_we_o !== 1'b1 || bus.rf_waddr_o !== 5'd3) begin
         $display("FAIL force_cyc0 got we=%b addr=%0d want 1/3", bus.rf_we_o, bus.rf_waddr_o);
         n_fail++;
      end
      for (int k = 1; k <= 4; k++) begin
         next_cyc();
         bus.mdu_valid_i = 1'b0;
         #1;
         n_checks++;
         if (bus.rf_waddr_o !== 5'd3 || bus.stall_w_o !== 1'b0 || bus.pend_valid_o !== 1'b1 ||
             bus.pend_rd_o !== 5'd7 || dut.wait_cnt_q !== 3'(k - 1)) begin
            $display("FAIL force_wait cyc%0d got addr=%0d stall=%b pend=%b prd=%0d cnt=%0d want 3/0/1/7/%0d",
                     k, bus.rf_waddr_o, bus.stall_w_o, bus.pend_valid_o, bus.pend_rd_o,
                     dut.wait_cnt_q, k - 1);
            n_fail++;
         end
      end
      next_cyc();
      #1;
      n_checks++;
      if (bus.rf_we_o !== 1'b1 || bus.rf_waddr_o !== 5'd7 || bus.rf_wdata_o !== 32'h77 ||
          bus.stall_w_o !== 1'b1 || dut.wait_cnt_q !== 3'd4) begin
         $display("FAIL force_cyc5 got we=%b addr=%0d data=%h stall=%b cnt=%0d want 1/7/77/1/4",
                  bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.stall_w_o, dut.wait_cnt_q);
         n_fail++;
      end
      next_cyc();
      #1;
      n_checks++;
      if (bus.rf_we_o !== 1'b1 || bus.rf_waddr_o !== 5'd3 || bus.rf_wdata_o !== 32'h33 ||
          bus.stall_w_o !== 1'b0 || bus.pend_valid_o !== 1'b0 || dut.wait_cnt_q !== 3'd0) begin
         $display("FAIL force_cyc6 got we=%b addr=%0d data=%h stall=%b pend=%b cnt=%0d want 1/3/33/0/0/0",
                  bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.stall_w_o, bus.pend_valid_o,
                  dut.wait_cnt_q);
         n_fail++;
      end
   endtask

   task automatic test_x0_writeback;
      do_reset();
      set_in(1'b1, 5'd0, 32'h11, 1'b1, 5'd9, 32'h99);
      #1;
      n_checks++;
      if (bus.rf_we_o !== 1'b0) begin
         $display("FAIL x0_cyc0 got we=%b want 0", bus.rf_we_o);
         n_fail++;
      end
      next_cyc();
      bus.mdu_valid_i = 1'b0;
      #1;
      n_checks++;
      if (bus.rf_we_o !== 1'b1 || bus.rf_waddr_o !== 5'd9 || bus.rf_wdata_o !== 32'h99 ||
          bus.stall_w_o !== 1'b0 || dut.wait_cnt_q !== 3'd0) begin
         $display("FAIL x0_grant got we=%b addr=%0d data=%h stall=%b cnt=%0d want 1/9/99/0/0",
                  bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.stall_w_o, dut.wait_cnt_q);
         n_fail++;
      end
      next_cyc();
      #1;
      n_checks++;
      if (bus.rf_we_o !== 1'b0 || dut.wait_cnt_q !== 3'd0 || bus.pend_valid_o !== 1'b0) begin
         $display("FAIL x0_after got we=%b cnt=%0d pend=%b want 0/0/0",
                  bus.rf_we_o, dut.wait_cnt_q, bus.pend_valid_o);
         n_fail++;
      end
   endtask

   task automatic test_mdu_rd0;
      do_reset();
      set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
      next_cyc();
      bus.mdu_valid_i = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         #1;
         n_checks++;
         if (bus.rf_we_o !== 1'b0 || bus.pend_valid_o !== 1'b0 || bus.mdu_ready_o !== 1'b1) begin
            $display("FAIL mdu_rd0 cyc%0d got we=%b pend=%b rdy=%b want 0/0/1",
                     k, bus.rf_we_o, bus.pend_valid_o, bus.mdu_ready_o);
            n_fail++;
         end
         next_cyc();
      end
   endtask

   task automatic test_back_to_back;
      do_reset();
      xfers = 0;
      set_in(1'b1, 5'd4, 32'h44, 1'b1, 5'd10, 32'hA0A0);
      #1;
      n_checks++;
      if (bus.mdu_ready_o !== 1'b1) begin
         $display("FAIL b2b_cyc0 got rdy=%b want 1", bus.mdu_ready_o);
         n_fail++;
      end
      next_cyc();
      bus.mdu_rd_i   = 5'd11;
      bus.mdu_data_i = 32'hB0B0;
      for (int k = 1; k <= 4; k++) begin
         #1;
         n_checks++;
         if (bus.mdu_ready_o !== 1'b0 || bus.pend_rd_o !== 5'd10 || bus.rf_waddr_o !== 5'd4) begin
            $display("FAIL b2b_full cyc%0d got rdy=%b prd=%0d addr=%0d want 0/10/4",
                     k, bus.mdu_ready_o, bus.pend_rd_o, bus.rf_waddr_o);
            n_fail++;
         end
         next_cyc();
      end
      #1;
      n_checks++;
      if (bus.mdu_ready_o !== 1'b0 || bus.rf_waddr_o !== 5'd10 || bus.rf_wdata_o !== 32'hA0A0) begin
         $display("FAIL b2b_grant got rdy=%b addr=%0d data=%h want 0/10/a0a0",
                  bus.mdu_ready_o, bus.rf_waddr_o, bus.rf_wdata_o);
         n_fail++;
      end
      next_cyc();
      #1;
      n_checks++;
      if (bus.mdu_ready_o !== 1'b1 || bus.rf_waddr_o !== 5'd4 || bus.stall_w_o !== 1'b0) begin
         $display("FAIL b2b_drain got rdy=%b addr=%0d stall=%b want 1/4/0",
                  bus.mdu_ready_o, bus.rf_waddr_o, bus.stall_w_o);
         n_fail++;
      end
      next_cyc();
      bus.mdu_valid_i = 1'b0;
      #1;
      n_checks++;
      if (bus.mdu_ready_o !== 1'b0 || bus.pend_valid_o !== 1'b1 || bus.pend_rd_o !== 5'd11 ||
          xfers !== 2) begin
         $display("FAIL b2b_reload got rdy=%b pend=%b prd=%0d xfers=%0d want 0/1/11/2",
                  bus.mdu_ready_o, bus.pend_valid_o, bus.pend_rd_o, xfers);
         n_fail++;
      end
   endtask

   task automatic test_reset_in_force;
      do_reset();
      set_in(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
      for (int k = 1; k <= 5; k++) begin
         next_cyc();
         bus.mdu_valid_i = 1'b0;
      end
      #1;
      n_checks++;
      if (bus.stall_w_o !== 1'b1 || bus.rf_waddr_o !== 5'd7) begin
         $display("FAIL rstforce_pre got stall=%b addr=%0d want 1/7", bus.stall_w_o, bus.rf_waddr_o);
         n_fail++;
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.rf_we_o !== 1'b0 || bus.stall_w_o !== 1'b0 || bus.pend_valid_o !== 1'b0 ||
          bus.rf_waddr_o !== 5'd0 || bus.pend_rd_o !== 5'd0) begin
         $display("FAIL rstforce_during got we=%b stall=%b pend=%b addr=%0d prd=%0d want 0/0/0/0/0",
                  bus.rf_we_o, bus.stall_w_o, bus.pend_valid_o, bus.rf_waddr_o, bus.pend_rd_o);
         n_fail++;
      end
      next_cyc();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         n_checks++;
         if (bus.stall_w_o !== 1'b0 || bus.pend_valid_o !== 1'b0 || bus.mdu_ready_o !== 1'b1 ||
             bus.rf_waddr_o !== 5'd3 || dut.wait_cnt_q !== 3'd0) begin
            $display("FAIL rstforce_after cyc%0d got stall=%b pend=%b rdy=%b addr=%0d cnt=%0d want 0/0/1/3/0",
                     k, bus.stall_w_o, bus.pend_valid_o, bus.mdu_ready_o, bus.rf_waddr_o, dut.wait_cnt_q);
            n_fail++;
         end
         next_cyc();
      end
   endtask

   initial begin
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      test_reset();
      test_idle_mdu();
      test_force_starvation();
      test_x0_writeback();
      test_mdu_rd0();
      test_back_to_back();
      test_reset_in_force();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
